instr_encoder_loader: RTL and testbench

Inverse of the instruction decoder. It accepts decoded instruction fields (opcode, op, Rn, Rd, Rm, shift, immediate) over a valid/ready handshake and packs them into 16-bit Simple RISC Machine instruction words. It range-checks immediates against their sign-extended field width, then writes the words to consecutive instruction-memory addresses. It is used by the test/boot loader path to fill program memory before the CPU is released from reset.

---
 rtl/instr_encoder_loader.sv | 122 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded fields into 16-bit instruction words and writes them to consecutive memory addresses.
// Optional HALT_WORD append after the final instruction is enabled by defining ENC_HALT_APPEND_EN.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = 16'hE000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic              enc_last,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [2:0]        Rn,
    input  logic [2:0]        Rd,
    input  logic [2:0]        Rm,
    input  logic [1:0]        shift,
    input  logic [15:0]       imm,
    input  logic              clear,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err_imm
);
`ifdef ENC_HALT_APPEND_EN
    typedef enum logic [2:0] {IDLE, WRITE, HALT, DONE, FULL} state_t;
`else
    typedef enum logic [2:0] {IDLE, WRITE, DONE, FULL} state_t;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              last_flag;
    logic              is_mov, is_mem, legal;
    logic [15:0]       word;

    assign is_mov = opcode == 3'b110 && op == 2'b10;
    assign is_mem = opcode == 3'b011 || opcode == 3'b100;
    // immediates must survive sign-extension from their field width
    assign legal = is_mov ? (&imm[15:7] | ~|imm[15:7]) :
                   is_mem ? (&imm[15:4] | ~|imm[15:4]) : 1'b1;
    assign word = is_mov ? {opcode, op, Rn, imm[7:0]} :
                  is_mem ? {opcode, op, Rn, Rd, imm[4:0]} :
                  opcode == HALT_WORD[15:13] ? {opcode, op, 11'b0} :
                  {opcode, op, Rn, Rd, shift, Rm};
    assign enc_ready = state == IDLE && !full && !done && !clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
            done      <= 1'b0;
            err_imm   <= 1'b0;
            addr      <= '0;
            last_flag <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            mem_write <= 1'b0;
            count     <= '0;
            full      <= 1'b0;
            done      <= 1'b0;
            err_imm   <= 1'b0;
            addr      <= '0;
        end else begin
            mem_write <= 1'b0;
            err_imm   <= 1'b0;
            case (state)
                IDLE: if (enc_valid && enc_ready) begin
                    if (legal) begin
                        state     <= WRITE;
                        mem_write <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= word;
                        last_flag <= enc_last;
                    end else begin
                        err_imm <= 1'b1;
                    end
                end
                WRITE: begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                    if (addr == LAST_ADDR) full <= 1'b1;
                    if (last_flag) begin
`ifdef ENC_HALT_APPEND_EN
                        if (addr != LAST_ADDR && mem_wdata[15:13] != HALT_WORD[15:13]) begin
                            state     <= HALT;
                            mem_write <= 1'b1;
                            mem_addr  <= addr + 1'b1;
                            mem_wdata <= HALT_WORD;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= addr == LAST_ADDR ? FULL : IDLE;
                    end
                end
`ifdef ENC_HALT_APPEND_EN
                HALT: begin
                    addr  <= addr + 1'b1;
                    count <= count + 1'b1;
                    if (addr == LAST_ADDR) full <= 1'b1;
                    state <= DONE;
                    done  <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and random bundles checked against a word-level memory model.
module tb_instr_encoder_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    logic          clk = 0, reset = 0, enc_valid = 0, enc_last = 0, clear = 0;
    logic          enc_ready, mem_write, full, done, err_imm;
    logic [2:0]    opcode = 0, Rn = 0, Rd = 0, Rm = 0;
    logic [1:0]    op = 0, shift = 0;
    logic [15:0]   imm = 0, mem_wdata, last_wdata;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   count;
    int            errors = 0, checks = 0;
    int            m_addr, m_count;
    bit            m_full, m_done;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .enc_last(enc_last), .opcode(opcode), .op(op), .Rn(Rn), .Rd(Rd), .Rm(Rm),
        .shift(shift), .imm(imm), .clear(clear), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full),
        .done(done), .err_imm(err_imm)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic bit legal_f(int opc, int o, int immv);
        if (opc == 6 && o == 2) return immv >= -128 && immv <= 127;
        if (opc == 3 || opc == 4) return immv >= -16 && immv <= 15;
        return 1;
    endfunction

    function automatic int enc_f(int opc, int o, int rn, int rd, int sh, int rm, int immv);
        if (opc == 6 && o == 2) return opc * 8192 + o * 2048 + rn * 256 + (immv & 255);
        if (opc == 3 || opc == 4) return opc * 8192 + o * 2048 + rn * 256 + rd * 32 + (immv & 31);
        if (opc == 7) return opc * 8192 + o * 2048;
        return opc * 8192 + o * 2048 + rn * 256 + rd * 32 + sh * 8 + rm;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_addr = 0; m_count = 0; m_full = 0; m_done = 0;
    endtask

    task automatic drive(int opc, int o, int rn, int rd, int sh, int rm, logic [15:0] im, bit lst, bit clr);
        int n = 0;
        @(negedge clk);
        opcode = 3'(opc); op = 2'(o); Rn = 3'(rn); Rd = 3'(rd); shift = 2'(sh); Rm = 3'(rm);
        imm = im; enc_last = lst; enc_valid = 1; clear = clr;
        while (!clr && !enc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1 enc_valid = 0; enc_last = 0; clear = 0;
    endtask

    task automatic post_check();
        chk("idle_wr", 32'(mem_write), 0);
        chk("err_low", 32'(err_imm), 0);
        chk("count", 32'(count), m_count);
        chk("full", 32'(full), 32'(m_full));
        chk("done", 32'(done), 32'(m_done));
        chk("ready", 32'(enc_ready), 32'(!m_full && !m_done));
    endtask

    task automatic send(int opc, int o, int rn, int rd, int sh, int rm, logic [15:0] im, bit lst);
        int immv = int'($signed(im));
        bit ok = legal_f(opc, o, immv);
        int wa;
        drive(opc, o, rn, rd, sh, rm, im, lst, 0);
        @(negedge clk);
        if (ok) begin
            chk("wr", 32'(mem_write), 1);
            chk("addr", 32'(mem_addr), m_addr);
            chk("data", 32'(mem_wdata), enc_f(opc, o, rn, rd, sh, rm, immv));
            last_wdata = mem_wdata;
            wa = m_addr; m_addr++; m_count++;
            if (wa == DEPTH - 1) m_full = 1;
            if (lst) begin
`ifdef ENC_HALT_APPEND_EN
                if (!m_full && opc != 7) begin
                    @(negedge clk);
                    chk("halt_wr", 32'(mem_write), 1);
                    chk("halt_addr", 32'(mem_addr), m_addr);
                    chk("halt_data", 32'(mem_wdata), 32'hE000);
                    wa = m_addr; m_addr++; m_count++;
                    if (wa == DEPTH - 1) m_full = 1;
                end
`endif
                m_done = 1;
            end
        end else begin
            chk("err_pulse", 32'(err_imm), 1);
            chk("err_nowr", 32'(mem_write), 0);
        end
        @(negedge clk);
        post_check();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        model_clear();
        @(negedge clk);
        post_check();
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        post_check();
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(mem_wdata), 0);
        // directed encodings
        send(6, 2, 0, 0, 0, 0, 16'd7, 0);
        chk("mov7", 32'(last_wdata), 32'hD007);
        send(5, 0, 1, 2, 1, 0, 16'd0, 0);
        chk("reg_a148", 32'(last_wdata), 32'hA148);
        send(3, 0, 1, 3, 0, 0, 16'hFFFE, 0);
        chk("ldr_617e", 32'(last_wdata), 32'h617E);
        send(6, 2, 0, 0, 0, 0, 16'hFFFF, 0);
        chk("mov_neg1", 32'(last_wdata), 32'hD0FF);
        send(6, 2, 0, 0, 0, 0, 16'h00C8, 0);
        chk("err_count", 32'(count), 4);
        // fill memory
        do_clear();
        for (int i = 0; i < DEPTH; i++) send(i % 6, i % 4, i % 8, (i + 3) % 8, i % 4, (i + 5) % 8, 16'd0, 0);
        chk("full_set", 32'(full), 1);
        chk("full_ready", 32'(enc_ready), 0);
        chk("full_count", 32'(count), DEPTH);
        do_clear();
        send(1, 1, 2, 3, 2, 1, 16'd0, 0);
        // last on second word
        do_clear();
        send(5, 0, 1, 2, 1, 0, 16'd0, 0);
        send(6, 2, 3, 0, 0, 0, 16'd3, 1);
`ifdef ENC_HALT_APPEND_EN
        chk("done_count", 32'(count), 3);
`else
        chk("done_count", 32'(count), 2);
`endif
        chk("done_flag", 32'(done), 1);
        // clear together with a valid bundle
        do_clear();
        send(2, 0, 1, 1, 0, 1, 16'd0, 0);
        drive(2, 1, 2, 2, 0, 2, 16'd0, 0, 1);
        model_clear();
        @(negedge clk);
        chk("clrv_wr", 32'(mem_write), 0);
        post_check();
        // clear while a write is in flight
        send(2, 0, 1, 1, 0, 1, 16'd0, 0);
        drive(2, 1, 2, 2, 0, 2, 16'd0, 0, 0);
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        model_clear();
        @(negedge clk);
        post_check();
        send(0, 3, 4, 5, 1, 6, 16'd0, 0);
        // reset while a write is in flight
        drive(0, 1, 1, 1, 1, 1, 16'd0, 0, 0);
        reset = 0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        post_check();
        chk("rstw_addr", 32'(mem_addr), 0);
        chk("rstw_data", 32'(mem_wdata), 0);
        reset = 1;
        // random bundles
        for (int i = 0; i < 120; i++) begin
            int opc = $urandom_range(0, 7);
            int o = (opc == 6 && $urandom_range(0, 1) == 1) ? 2 : $urandom_range(0, 3);
            logic [15:0] im = $urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 300) - 150);
            if ($urandom_range(0, 1) == 1) im = 16'($urandom_range(0, 40) - 20);
            send(opc, o, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 7), im, $urandom_range(0, 19) == 0);
            if (m_full || m_done) do_clear();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
